// File: rtl/port_axil_csr_if.sv
// ---------------------------------------------------------------------------
// port_axil_csr_if
//   AXI4-lite register bus between the NIOS-V interconnect and a traffic
//   port's CSR block.
//
//   Each channel uses valid/ready: a beat transfers on a rising clock edge
//   where both valid and ready are high. The sender holds valid and payload
//   stable until that edge. The receiver may raise or drop ready freely.
//
//   Signals (named as seen from the bus):
//     axi_aw*  write address channel  (awaddr, awvalid, awready)
//     axi_w*   write data channel     (wdata, wstrb, wvalid, wready)
//     axi_b*   write response channel (bresp, bvalid, bready)
//     axi_ar*  read address channel   (araddr, arvalid, arready)
//     axi_r*   read data channel      (rdata, rresp, rvalid, rready)
//   Modports: master drives addresses, data and the response readies;
//             slave drives the address/data readies and the responses.
// ---------------------------------------------------------------------------
interface port_axil_csr_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] axi_awaddr;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [31:0]       axi_wdata;
    logic [3:0]        axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;
    logic [ADDR_W-1:0] axi_araddr;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [31:0]       axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rvalid;
    logic              axi_rready;

    modport master (
        output axi_awaddr, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_araddr, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid,
        output axi_rready
    );

    modport slave (
        input  axi_awaddr, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_araddr, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid,
        input  axi_rready
    );
endinterface

// File: rtl/port_axil_csr.sv
// ---------------------------------------------------------------------------
// port_axil_csr
//   AXI4-lite slave CSR block for one traffic port. It drives the static
//   transceiver controls and reports PLL/link status, an error counter and a
//   sticky link-change interrupt. Everything runs in the sys_clk domain.
//
//   Ports:
//     sys_clk, sys_rst     register clock, synchronous active-high reset
//     bus                  AXI4-lite slave (port_axil_csr_if.slave)
//     pll_locked[1:0]      [0]=10G ATX, [1]=1G ATX lock (sys_clk domain)
//     link_up              PCS link status (sys_clk domain)
//     err_pulse            one-cycle error event
//     ctrl_tx_en/rx_en/loopback/rate_sel   CTRL register bits
//     irq                  level interrupt = IRQ[0] & IRQ_EN[0]
//
//   Register map (word index = addr[ADDR_W-1:2]):
//     0x000 ID      RO   ID_VALUE
//     0x004 CTRL    RW   [0] tx_en [1] rx_en [2] loopback [3] rate_sel
//     0x008 STATUS  RO   [0] link_up [2:1] pll_locked
//     0x00C SCRATCH RW   32 bits
//     0x010 ERR_CNT RO   clear-on-read, saturating
//     0x014 IRQ     W1C  [0] sticky link_up change
//     0x018 IRQ_EN  RW   [0]
// ---------------------------------------------------------------------------
module port_axil_csr #(
    parameter logic [31:0] ID_VALUE = 32'hB5C0_0001,
    parameter int          ADDR_W   = 12
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    port_axil_csr_if.slave       bus,
    input  logic [1:0]           pll_locked,
    input  logic                 link_up,
    input  logic                 err_pulse,
    output logic                 ctrl_tx_en,
    output logic                 ctrl_rx_en,
    output logic                 ctrl_loopback,
    output logic                 ctrl_rate_sel,
    output logic                 irq
);

    localparam int IDX_W = ADDR_W - 2;

    localparam logic [IDX_W-1:0] REG_ID      = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_CTRL    = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_STATUS  = IDX_W'(2);
    localparam logic [IDX_W-1:0] REG_SCRATCH = IDX_W'(3);
    localparam logic [IDX_W-1:0] REG_ERR_CNT = IDX_W'(4);
    localparam logic [IDX_W-1:0] REG_IRQ     = IDX_W'(5);
    localparam logic [IDX_W-1:0] REG_IRQ_EN  = IDX_W'(6);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ---------------------------------------------------------------- state
    logic             aw_held;
    logic             w_held;
    logic [IDX_W-1:0] awidx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    logic             awready_q;
    logic             wready_q;
    logic             bvalid_q;
    logic [1:0]       bresp_q;

    logic             arready_q;
    logic             rvalid_q;
    logic [31:0]      rdata_q;
    logic [1:0]       rresp_q;

    logic [3:0]       ctrl_q;
    logic [31:0]      scratch_q;
    logic [31:0]      err_cnt_q;
    logic             irq_stat_q;
    logic             irq_en_q;
    logic             link_q;

    // --------------------------------------------------------- handshakes
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign aw_hs = bus.axi_awvalid & awready_q;
    assign w_hs  = bus.axi_wvalid  & wready_q;
    assign b_hs  = bvalid_q & bus.axi_bready;
    assign ar_hs = bus.axi_arvalid & arready_q;
    assign r_hs  = rvalid_q & bus.axi_rready;

    // Byte offset bits are ignored by the decoder.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{bus.axi_awaddr[1:0], bus.axi_araddr[1:0]};

    // ---------------------------------------------------------- write path
    // The write fires in the same edge as the later of the two handshakes,
    // taking each field either from its holding register or straight from
    // the bus if that beat is transferring now.
    logic             wr_fire;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic [3:0]       wr_strb;
    logic             wr_mapped;
    logic             aw_held_n;
    logic             w_held_n;
    logic             bvalid_n;

    always_comb begin
        wr_fire   = (aw_held | aw_hs) & (w_held | w_hs);
        wr_idx    = aw_held ? awidx_q : bus.axi_awaddr[ADDR_W-1:2];
        wr_data   = w_held  ? wdata_q : bus.axi_wdata;
        wr_strb   = w_held  ? wstrb_q : bus.axi_wstrb;
        wr_mapped = (wr_idx <= REG_IRQ_EN);
        aw_held_n = ~wr_fire & (aw_held | aw_hs);
        w_held_n  = ~wr_fire & (w_held  | w_hs);
        bvalid_n  = wr_fire | (bvalid_q & ~b_hs);
    end

    logic wr_ctrl;
    logic wr_scratch;
    logic wr_irq_en;
    logic irq_w1c;

    assign wr_ctrl    = wr_fire & (wr_idx == REG_CTRL);
    assign wr_scratch = wr_fire & (wr_idx == REG_SCRATCH);
    assign wr_irq_en  = wr_fire & (wr_idx == REG_IRQ_EN);
    assign irq_w1c    = wr_fire & (wr_idx == REG_IRQ) & wr_strb[0] & wr_data[0];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            bvalid_q <= bvalid_n;
            if (aw_hs) begin
                awidx_q <= bus.axi_awaddr[ADDR_W-1:2];
            end
            if (w_hs) begin
                wdata_q <= bus.axi_wdata;
                wstrb_q <= bus.axi_wstrb;
            end
            if (wr_fire) begin
                bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end
            // A channel re-opens only once nothing is held and no response
            // is outstanding; this also raises both readies the first cycle
            // after reset release.
            awready_q <= ~aw_held_n & ~bvalid_n;
            wready_q  <= ~w_held_n  & ~bvalid_n;
        end
    end

    // ----------------------------------------------------------- read path
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_val;
    logic             rd_mapped;
    logic             rvalid_n;

    assign rd_idx   = bus.axi_araddr[ADDR_W-1:2];
    assign rvalid_n = ar_hs | (rvalid_q & ~r_hs);

    always_comb begin
        rd_val    = '0;
        rd_mapped = 1'b1;
        case (rd_idx)
            REG_ID:      rd_val = ID_VALUE;
            REG_CTRL:    rd_val = {28'd0, ctrl_q};
            REG_STATUS:  rd_val = {29'd0, pll_locked, link_up};
            REG_SCRATCH: rd_val = scratch_q;
            REG_ERR_CNT: rd_val = err_cnt_q;
            REG_IRQ:     rd_val = {31'd0, irq_stat_q};
            REG_IRQ_EN:  rd_val = {31'd0, irq_en_q};
            default:     rd_mapped = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rvalid_q  <= rvalid_n;
            arready_q <= ~rvalid_n;
            // rd_val samples the registers before this edge's write lands,
            // so a same-cycle read of a register being written sees the old
            // value.
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------ registers
    logic err_cnt_rd;
    logic link_edge;

    assign err_cnt_rd = ar_hs & (rd_idx == REG_ERR_CNT);
    assign link_edge  = link_up ^ link_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ctrl_q     <= '0;
            scratch_q  <= '0;
            err_cnt_q  <= '0;
            irq_stat_q <= 1'b0;
            irq_en_q   <= 1'b0;
            link_q     <= 1'b0;
        end else begin
            if (wr_ctrl && wr_strb[0]) begin
                ctrl_q <= wr_data[3:0];
            end
            if (wr_scratch) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb[b]) begin
                        scratch_q[8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            if (wr_irq_en && wr_strb[0]) begin
                irq_en_q <= wr_data[0];
            end

            // Clear-on-read keeps an event landing in the capture cycle by
            // loading it instead of zero, so no error is ever lost.
            if (err_cnt_rd) begin
                err_cnt_q <= {31'd0, err_pulse};
            end else if (err_pulse && (err_cnt_q != 32'hFFFF_FFFF)) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end

            // A new edge wins over a simultaneous W1C.
            link_q     <= link_up;
            irq_stat_q <= link_edge | (irq_stat_q & ~irq_w1c);
        end
    end

    // -------------------------------------------------------------- outputs
    assign bus.axi_awready = awready_q;
    assign bus.axi_wready  = wready_q;
    assign bus.axi_bvalid  = bvalid_q;
    assign bus.axi_bresp   = bresp_q;
    assign bus.axi_arready = arready_q;
    assign bus.axi_rvalid  = rvalid_q;
    assign bus.axi_rdata   = rdata_q;
    assign bus.axi_rresp   = rresp_q;

    assign ctrl_tx_en    = ctrl_q[0];
    assign ctrl_rx_en    = ctrl_q[1];
    assign ctrl_loopback = ctrl_q[2];
    assign ctrl_rate_sel = ctrl_q[3];
    assign irq           = irq_stat_q & irq_en_q;

endmodule

// File: tb/tb_port_axil_csr.sv
// ---------------------------------------------------------------------------
// tb_port_axil_csr
//   Directed bench for port_axil_csr. Inputs change 1 ns after a rising edge
//   and outputs are sampled at the same point. Expected read responses are
//   queued when a read is issued and popped when rvalid is observed.
// ---------------------------------------------------------------------------
module tb_port_axil_csr;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] pll_locked;
    logic       link_up;
    logic       err_pulse;
    logic       ctrl_tx_en;
    logic       ctrl_rx_en;
    logic       ctrl_loopback;
    logic       ctrl_rate_sel;
    logic       irq;

    port_axil_csr_if #(.ADDR_W(12)) bus ();

    port_axil_csr #(
        .ID_VALUE (32'hB5C0_0001),
        .ADDR_W   (12)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .bus           (bus),
        .pll_locked    (pll_locked),
        .link_up       (link_up),
        .err_pulse     (err_pulse),
        .ctrl_tx_en    (ctrl_tx_en),
        .ctrl_rx_en    (ctrl_rx_en),
        .ctrl_loopback (ctrl_loopback),
        .ctrl_rate_sel (ctrl_rate_sel),
        .irq           (irq)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_bits();
        return {28'd0, ctrl_rate_sel, ctrl_loopback, ctrl_rx_en, ctrl_tx_en};
    endfunction

    task automatic do_read(input logic [11:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input logic err_at_cap,
                           input string tag);
        int          n;
        logic [31:0] ed;
        logic [1:0]  er;
        exp_q.push_back(exp_data);
        exp_resp_q.push_back(exp_resp);
        bus.axi_araddr  = addr;
        bus.axi_arvalid = 1'b1;
        err_pulse       = err_at_cap;
        n = 0;
        while (!bus.axi_arready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_arready"}, 32'(bus.axi_arready), 32'd1);
        tick();
        bus.axi_arvalid = 1'b0;
        err_pulse       = 1'b0;
        check({tag, "_rvalid_lat1"}, 32'(bus.axi_rvalid), 32'd1);
        check({tag, "_arready_busy"}, 32'(bus.axi_arready), 32'd0);
        bus.axi_rready = 1'b1;
        ed = exp_q.pop_front();
        er = exp_resp_q.pop_front();
        check({tag, "_rdata"}, bus.axi_rdata, ed);
        check({tag, "_rresp"}, 32'(bus.axi_rresp), 32'(er));
        tick();
        bus.axi_rready = 1'b0;
        check({tag, "_rvalid_drop"}, 32'(bus.axi_rvalid), 32'd0);
        check({tag, "_arready_back"}, 32'(bus.axi_arready), 32'd1);
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int b_hold,
                            input logic link_flip, input logic [1:0] exp_bresp,
                            input string tag);
        int n;
        bus.axi_awaddr = addr;
        bus.axi_wdata  = data;
        bus.axi_wstrb  = strb;
        if (w_lead > 0) begin
            bus.axi_wvalid = 1'b1;
            n = 0;
            while (!bus.axi_wready && n < 20) begin
                tick();
                n++;
            end
            check({tag, "_wready"}, 32'(bus.axi_wready), 32'd1);
            tick();
            bus.axi_wvalid = 1'b0;
            for (int i = 1; i < w_lead; i++) begin
                check({tag, "_wready_held_low"}, 32'(bus.axi_wready), 32'd0);
                check({tag, "_no_early_bvalid"}, 32'(bus.axi_bvalid), 32'd0);
                tick();
            end
            bus.axi_awvalid = 1'b1;
            if (link_flip) link_up = ~link_up;
            n = 0;
            while (!bus.axi_awready && n < 20) begin
                tick();
                n++;
            end
            check({tag, "_awready"}, 32'(bus.axi_awready), 32'd1);
            tick();
            bus.axi_awvalid = 1'b0;
        end else begin
            bus.axi_awvalid = 1'b1;
            bus.axi_wvalid  = 1'b1;
            if (link_flip) link_up = ~link_up;
            n = 0;
            while (!(bus.axi_awready && bus.axi_wready) && n < 20) begin
                tick();
                n++;
            end
            check({tag, "_aw_w_ready"}, 32'(bus.axi_awready & bus.axi_wready), 32'd1);
            tick();
            bus.axi_awvalid = 1'b0;
            bus.axi_wvalid  = 1'b0;
        end
        check({tag, "_bvalid_lat1"}, 32'(bus.axi_bvalid), 32'd1);
        for (int i = 0; i < b_hold; i++) begin
            check({tag, "_bvalid_hold"}, 32'(bus.axi_bvalid), 32'd1);
            check({tag, "_bresp_hold"}, 32'(bus.axi_bresp), 32'(exp_bresp));
            check({tag, "_awready_hold"}, 32'(bus.axi_awready), 32'd0);
            check({tag, "_wready_hold"}, 32'(bus.axi_wready), 32'd0);
            tick();
        end
        bus.axi_bready = 1'b1;
        check({tag, "_bresp"}, 32'(bus.axi_bresp), 32'(exp_bresp));
        tick();
        bus.axi_bready = 1'b0;
        check({tag, "_bvalid_drop"}, 32'(bus.axi_bvalid), 32'd0);
        check({tag, "_awready_back"}, 32'(bus.axi_awready), 32'd1);
        check({tag, "_wready_back"}, 32'(bus.axi_wready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst         = 1'b1;
        pll_locked      = 2'b01;
        link_up         = 1'b0;
        err_pulse       = 1'b0;
        bus.axi_awaddr  = '0;
        bus.axi_awvalid = 1'b0;
        bus.axi_wdata   = '0;
        bus.axi_wstrb   = '0;
        bus.axi_wvalid  = 1'b0;
        bus.axi_bready  = 1'b0;
        bus.axi_araddr  = '0;
        bus.axi_arvalid = 1'b0;
        bus.axi_rready  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_awready", 32'(bus.axi_awready), 32'd0);
        check("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(bus.axi_rvalid), 32'd0);
        check("rst_rdata", bus.axi_rdata, 32'd0);
        check("rst_ctrl", ctrl_bits(), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        sys_rst = 1'b0;
        tick();
        check("rel_readies", 32'({bus.axi_awready, bus.axi_wready, bus.axi_arready}), 32'd7);

        // ID and STATUS
        do_read(12'h000, 32'hB5C0_0001, 2'b00, 1'b0, "id");
        do_read(12'h008, 32'h0000_0002, 2'b00, 1'b0, "status");

        // CTRL: W leads AW by 3 cycles, only byte 0 strobed
        do_write(12'h004, 32'h0000_000F, 4'h1, 3, 0, 1'b0, 2'b00, "ctrl_wr");
        check("ctrl_outputs", ctrl_bits(), 32'h0000_000F);
        do_read(12'h004, 32'h0000_000F, 2'b00, 1'b0, "ctrl_rd");

        // SCRATCH with byte strobes and a stalled B channel
        do_write(12'h00C, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, 2'b00, "scr_full");
        do_write(12'h00C, 32'h1122_3344, 4'h5, 0, 5, 1'b0, 2'b00, "scr_strb");
        do_read(12'h00D, 32'hDE22_BE44, 2'b00, 1'b0, "scr_rd");

        // ERR_CNT clear-on-read
        repeat (3) begin
            err_pulse = 1'b1;
            tick();
            err_pulse = 1'b0;
            tick();
        end
        do_read(12'h010, 32'd3, 2'b00, 1'b0, "err3");
        do_read(12'h010, 32'd0, 2'b00, 1'b1, "err_cap");
        do_read(12'h010, 32'd1, 2'b00, 1'b0, "err_after");

        // Link-change interrupt
        do_write(12'h018, 32'h0000_0001, 4'h1, 0, 0, 1'b0, 2'b00, "irq_en");
        check("irq_idle", 32'(irq), 32'd0);
        link_up = 1'b1;
        tick();
        tick();
        check("irq_set", 32'(irq), 32'd1);
        do_read(12'h014, 32'd1, 2'b00, 1'b0, "irq_rd1");
        do_write(12'h014, 32'h0000_0001, 4'h1, 0, 0, 1'b1, 2'b00, "w1c_edge");
        check("irq_edge_wins", 32'(irq), 32'd1);
        do_write(12'h014, 32'h0000_0001, 4'h1, 0, 0, 1'b0, 2'b00, "w1c");
        check("irq_cleared", 32'(irq), 32'd0);
        do_read(12'h014, 32'd0, 2'b00, 1'b0, "irq_rd0");

        // Unmapped accesses
        do_read(12'h100, 32'd0, 2'b10, 1'b0, "unmapped_rd");
        do_write(12'h200, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0, 2'b10, "unmapped_wr");
        do_read(12'h00C, 32'hDE22_BE44, 2'b00, 1'b0, "scr_intact");
        do_read(12'h004, 32'h0000_000F, 2'b00, 1'b0, "ctrl_intact");
        do_read(12'h018, 32'd1, 2'b00, 1'b0, "irqen_intact");

        // Reset with AW latched and W still pending
        bus.axi_awaddr  = 12'h00C;
        bus.axi_awvalid = 1'b1;
        tick();
        bus.axi_awvalid = 1'b0;
        check("aw_latched", 32'(bus.axi_awready), 32'd0);
        sys_rst = 1'b1;
        tick();
        tick();
        check("abort_bvalid_rst", 32'(bus.axi_bvalid), 32'd0);
        sys_rst = 1'b0;
        tick();
        check("abort_readies", 32'({bus.axi_awready, bus.axi_wready, bus.axi_arready}), 32'd7);
        check("abort_ctrl", ctrl_bits(), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_bvalid", 32'(bus.axi_bvalid), 32'd0);
            tick();
        end
        do_read(12'h00C, 32'd0, 2'b00, 1'b0, "scr_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/port_axil_csr.md
Name: port_axil_csr

Overview:
- AXI4-lite slave control/status register block that terminates the per-port `axi_*` register bus inside each traffic port.
- Drives the static controls of the port's transceiver datapath: TX/RX enable, loopback and 10G/1G rate select.
- Returns PLL and link status, an error counter and a sticky link-change interrupt to the NIOS-V.
- Runs entirely in the `sys_clk` domain.

Parameters:
- `ID_VALUE`, 32'hB5C0_0001, constant returned by the ID register.
- `ADDR_W`, 12, AXI address width.

Ports:
- `sys_clk`  in  1  register clock.
- `sys_rst`  in  1  synchronous reset, active-high.
- `axi_awaddr`  in  ADDR_W  write address.
- `axi_awvalid`/`axi_awready`  in/out  1  write-address handshake.
- `axi_wdata`  in  32  write data.
- `axi_wstrb`  in  4  byte strobes.
- `axi_wvalid`/`axi_wready`  in/out  1  write-data handshake.
- `axi_bresp`  out  2  write response.
- `axi_bvalid`/`axi_bready`  out/in  1  write-response handshake.
- `axi_araddr`  in  ADDR_W  read address.
- `axi_arvalid`/`axi_arready`  in/out  1  read-address handshake.
- `axi_rdata`  out  32  read data.
- `axi_rresp`  out  2  read response.
- `axi_rvalid`/`axi_rready`  out/in  1  read-data handshake.
- `pll_locked`  in  2  [0]=10G ATX, [1]=1G ATX; already in `sys_clk` domain.
- `link_up`  in  1  PCS link status; already in `sys_clk` domain.
- `err_pulse`  in  1  one-cycle error event.
- `ctrl_tx_en`, `ctrl_rx_en`, `ctrl_loopback`, `ctrl_rate_sel`  out  1 each  CTRL register bits.
- `irq`  out  1  level interrupt.

Behaviour:
- Reset values: all ready/valid outputs 0 except `axi_awready`=`axi_wready`=`axi_arready`=1 one cycle after reset release. `bresp`/`rresp`/`rdata` = 0; all ctrl outputs 0; `irq` 0; all registers 0.
- Decode uses `addr[ADDR_W-1:2]`; `addr[1:0]` are ignored.
- Register map:
  - 0x000 ID, RO, returns `ID_VALUE`.
  - 0x004 CTRL, RW, [0] `tx_en`, [1] `rx_en`, [2] `loopback`, [3] `rate_sel` (0=10G, 1=1G); bits [31:4] read 0.
  - 0x008 STATUS, RO, [0] `link_up`, [2:1] `pll_locked`.
  - 0x00C SCRATCH, RW, 32 bits.
  - 0x010 ERR_CNT, RO, clear-on-read, saturates at 32'hFFFF_FFFF.
  - 0x014 IRQ, W1C, [0] sticky `link_up` change; `irq` = IRQ[0] & IRQ_EN[0].
  - 0x018 IRQ_EN, RW, bit [0].
- RW registers honour `wstrb` per byte lane. Writes to RO registers are ignored and return OKAY.
- Unmapped address: write dropped, `bresp`=2'b10 (SLVERR); read returns `rdata`=0, `rresp`=2'b10.
- Write channel, AW and W are accepted independently:
  - A channel whose beat is latched drops its ready until the write completes.
  - The write executes in the cycle after both beats are held. `bvalid` rises in that same cycle (latency 1 from the later handshake).
  - `bvalid` holds with stable `bresp` until `bready`. Both readies return to 1 the cycle after the B handshake.
- Read channel:
  - `arready`=1 whenever `rvalid`=0.
  - After the AR handshake, `rvalid` and `rdata` are registered on the next cycle. `arready` stays 0 until the R handshake completes.
- Read and write channels operate concurrently. A same-cycle read and write to the same register returns the pre-write value.
- ERR_CNT:
  - Increments on `err_pulse`.
  - A read returns the pre-event value. In the cycle the read is captured, the counter loads `err_pulse` (1 or 0) instead of clearing to 0.
  - At saturation it holds; a read still clears it.
- Link-change interrupt: `link_up` is registered once; any edge sets IRQ[0]. A same-cycle W1C and new edge leaves IRQ[0]=1.
- `sys_rst` mid-transaction aborts any pending beat and restores reset values; no response is issued for the aborted transaction.

Test Plan:
- Read 0x000 after reset -> `rdata`=32'hB5C0_0001, `rresp`=0, `rvalid` exactly one cycle after AR handshake.
- W before AW by 3 cycles, write 0x004 data 0xF, `wstrb`=4'h1 -> `bvalid` 1 cycle after AW handshake, `bresp`=0, all four ctrl outputs=1; readback 0x0000_000F.
- SCRATCH: write 0xDEADBEEF, then write 0x11223344 with `wstrb`=4'b0101 -> read 0xDE22BE44. `bready` held low 5 cycles -> `bvalid` and `bresp` stable, `awready`=0 throughout.
- Three `err_pulse`s then read 0x010 -> 3. Read again with `err_pulse` in the capture cycle -> 0, then next read -> 1.
- IRQ_EN=1, toggle `link_up` -> `irq`=1. W1C IRQ in the same cycle as another `link_up` edge -> `irq` stays 1. A later W1C -> `irq`=0.
- Read 0x100 and write 0x200 -> `rresp`=2'b10, `rdata`=0, `bresp`=2'b10, no register changed. Assert `sys_rst` with AW latched and W pending -> no `bvalid`, readies=1 after release.
